// File: rtl/err_compute.sv
// err_compute: line-sensor error producer.
// Walks the eight IR channels through the A2D request/ready handshake and
// accumulates a signed, position-weighted sum. At the end of each sweep it
// publishes an 11-bit saturated error, a line-present flag and a one-cycle
// err_vld strobe.
// Optional feature macro: ERR_FILTER_EN. When defined, the published error is
// a 3/4-old + 1/4-new IIR blend of the saturated sweep error.
module err_compute #(
    parameter int          SWEEP_CYCLES = 4096,
    parameter logic [11:0] LINE_THRESH  = 12'h200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    output logic               a2d_req,
    output logic [2:0]         a2d_chnnl,
    input  logic               a2d_rdy,
    input  logic [11:0]        a2d_res,
    output logic signed [10:0] err_sat,
    output logic               err_vld,
    output logic               line_present
);

    localparam int DATA_W = 12;
    localparam int ACC_W  = 17;
    localparam int ERR_W  = 11;
    localparam int TMR_W  = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;

    localparam logic signed [ACC_W-1:0] ERR_MAX = 17'sd1023;
    localparam logic signed [ACC_W-1:0] ERR_MIN = -17'sd1024;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACC,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [2:0]               chnnl_q, chnnl_d;
    logic [DATA_W-1:0]        res_q, res_d;
    logic signed [ACC_W-1:0]  accum_q, accum_d;
    logic                     line_seen_q, line_seen_d;
    logic signed [ERR_W-1:0]  err_q, err_d;
    logic                     vld_q, vld_d;
    logic                     line_q, line_d;

    logic                     tmr_wrap;
    logic                     start;
    logic [1:0]               shamt;
    logic signed [ACC_W-1:0]  res_ext;
    logic signed [ACC_W-1:0]  term;

    // Floor-divide the accumulator by 16 and clamp into the 11-bit error range.
    function automatic logic signed [ERR_W-1:0] sat11(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> 4;
        if (s > ERR_MAX)
            sat11 = ERR_MAX[ERR_W-1:0];
        else if (s < ERR_MIN)
            sat11 = ERR_MIN[ERR_W-1:0];
        else
            sat11 = s[ERR_W-1:0];
    endfunction

`ifdef ERR_FILTER_EN
    // (3*prev + cur) >>> 2 in 13 bits; the extremes (+-4096 range) cannot overflow
    // and the floored quotient always lands back inside the 11-bit range.
    function automatic logic signed [ERR_W-1:0] filt(input logic signed [ERR_W-1:0] prev,
                                                     input logic signed [ERR_W-1:0] cur);
        logic signed [12:0] prev_x;
        logic signed [12:0] cur_x;
        logic signed [12:0] sum;
        logic signed [12:0] q;
        prev_x = $signed({{2{prev[ERR_W-1]}}, prev});
        cur_x  = $signed({{2{cur[ERR_W-1]}}, cur});
        sum    = (prev_x <<< 1) + prev_x + cur_x;
        q      = sum >>> 2;
        filt   = q[ERR_W-1:0];
    endfunction
`endif

    // Weighted term: |weight| is 8,4,2,1 for ch0..3 and 1,2,4,8 for ch4..7, so the
    // shift is the low channel bits, inverted on the negative (left) half.
    always_comb begin
        shamt   = chnnl_q[2] ? chnnl_q[1:0] : ~chnnl_q[1:0];
        res_ext = $signed({{(ACC_W-DATA_W){1'b0}}, res_q});
        term    = res_ext <<< shamt;
    end

    // Sweep timer, start decision and the sequencing FSM next-state logic.
    always_comb begin
        tmr_wrap    = (tmr_q == TMR_W'(SWEEP_CYCLES - 1));
        tmr_d       = tmr_wrap ? '0 : tmr_q + 1'b1;
        start       = tmr_wrap && go && (state_q == IDLE);

        state_d     = state_q;
        chnnl_d     = chnnl_q;
        res_d       = res_q;
        accum_d     = accum_q;
        line_seen_d = line_seen_q;
        err_d       = err_q;
        line_d      = line_q;
        vld_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = REQ;
                    accum_d     = '0;
                    line_seen_d = 1'b0;
                    chnnl_d     = 3'd0;
                end
            end
            REQ: begin
                if (a2d_rdy) begin
                    res_d   = a2d_res;
                    state_d = ACC;
                end
            end
            ACC: begin
                accum_d = chnnl_q[2] ? (accum_q + term) : (accum_q - term);
                if (res_q > LINE_THRESH)
                    line_seen_d = 1'b1;
                if (chnnl_q == 3'd7) begin
                    // Outputs load on entry to DONE so they change together
                    // with the err_vld strobe that DONE presents.
                    state_d = DONE;
`ifdef ERR_FILTER_EN
                    err_d   = filt(err_q, sat11(accum_d));
`else
                    err_d   = sat11(accum_d);
`endif
                    line_d  = line_seen_d;
                    vld_d   = 1'b1;
                end else begin
                    chnnl_d = chnnl_q + 3'd1;
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and published outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            chnnl_q <= 3'd0;
            err_q   <= '0;
            vld_q   <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            chnnl_q <= chnnl_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            line_q  <= line_d;
        end
    end

    // Sweep datapath; always initialised at sweep start, so no reset needed.
    always_ff @(posedge clk) begin
        res_q       <= res_d;
        accum_q     <= accum_d;
        line_seen_q <= line_seen_d;
    end

    assign a2d_req      = (state_q == REQ);
    assign a2d_chnnl    = chnnl_q;
    assign err_sat      = err_q;
    assign err_vld      = vld_q;
    assign line_present = line_q;

endmodule

// File: tb/tb_err_compute.sv
// Testbench for err_compute: A2D responder, sweep-level reference model and
// directed sweeps with hand-computed expectations.
module tb_err_compute;

    localparam int SWEEP = 256;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               go;
    logic               a2d_req;
    logic [2:0]         a2d_chnnl;
    logic               a2d_rdy;
    logic [11:0]        a2d_res;
    logic signed [10:0] err_sat;
    logic               err_vld;
    logic               line_present;

    int checks   = 0;
    int failures = 0;

    logic [11:0] chan_val [8];
    int          dly_mode = 0;   // <0: random 0..20 cycles, otherwise fixed delay

    err_compute #(
        .SWEEP_CYCLES (SWEEP),
        .LINE_THRESH  (12'h200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .a2d_req      (a2d_req),
        .a2d_chnnl    (a2d_chnnl),
        .a2d_rdy      (a2d_rdy),
        .a2d_res      (a2d_res),
        .err_sat      (err_sat),
        .err_vld      (err_vld),
        .line_present (line_present)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Sweep error from the weighting rule: sum(w*v), floor /16, clamp to 11 bits.
    function automatic int model_err(input int prev);
        int s;
        int q;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            int w;
            w = (i < 4) ? -(8 >> i) : (1 << (i - 4));
            s += w * int'(chan_val[i]);
        end
        q = s >>> 4;
        if (q > 1023)  q = 1023;
        if (q < -1024) q = -1024;
`ifdef ERR_FILTER_EN
        return (3 * prev + q) >>> 2;
`else
        if (prev == 12345) q = q;  // prev only matters for the filtered build
        return q;
`endif
    endfunction

    function automatic bit model_line();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++)
            if (int'(chan_val[i]) > 'h200) seen = 1'b1;
        return seen;
    endfunction

    // A2D responder: answers each request after the configured delay.
    initial begin
        bit armed;
        int wc;
        armed   = 1'b0;
        wc      = 0;
        a2d_rdy = 1'b0;
        a2d_res = '0;
        forever begin
            @(posedge clk);
            #2;
            a2d_rdy = 1'b0;
            if (!rst_n) begin
                armed = 1'b0;
            end else if (a2d_req) begin
                if (!armed) begin
                    armed = 1'b1;
                    wc = (dly_mode < 0) ? int'($urandom_range(0, 20)) : dly_mode;
                end
                if (wc == 0) begin
                    a2d_rdy = 1'b1;
                    a2d_res = chan_val[a2d_chnnl];
                    armed   = 1'b0;
                end else begin
                    wc--;
                end
            end
        end
    end

    // Compare process: every cycle checks strobe, error and line flag against
    // the model, and the channel order of every accepted handshake.
    int exp_err    = 0;
    int exp_line   = 0;
    int pend_err   = 0;
    int pend_line  = 0;
    int cd         = 0;
    int hs_idx     = 0;
    bit reset_pend = 1'b1;

    always @(negedge clk) begin
        int exp_vld;
        if (reset_pend) begin
            exp_err = 0;
            exp_line = 0;
            cd = 0;
            hs_idx = 0;
            check("req_after_rst", int'(a2d_req), 0);
        end
        exp_vld = (cd == 1) ? 1 : 0;
        if (cd > 0) cd--;
        if (exp_vld == 1) begin
            exp_err  = pend_err;
            exp_line = pend_line;
        end
        check("err_vld", int'(err_vld), exp_vld);
        check("err_sat", int'(err_sat), exp_err);
        check("line_present", int'(line_present), exp_line);
        reset_pend = (rst_n == 1'b0);
        if (rst_n && a2d_req === 1'b1 && a2d_rdy) begin
            check("chnnl_order", int'(a2d_chnnl), hs_idx);
            hs_idx++;
            if (hs_idx == 8) begin
                hs_idx    = 0;
                cd        = 2;
                pend_err  = model_err(exp_err);
                pend_line = int'(model_line());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_vals(input int c0, input int c1, input int c2, input int c3,
                            input int c4, input int c5, input int c6, input int c7);
        chan_val[0] = 12'(c0); chan_val[1] = 12'(c1);
        chan_val[2] = 12'(c2); chan_val[3] = 12'(c3);
        chan_val[4] = 12'(c4); chan_val[5] = 12'(c5);
        chan_val[6] = 12'(c6); chan_val[7] = 12'(c7);
    endtask

    task automatic run_sweep(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3 * SWEEP) begin
            tick(1);
            n++;
            if (err_vld) seen = 1'b1;
        end
        check({name, "_vld_seen"}, int'(seen), 1);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!a2d_req && n < 3 * SWEEP) begin
            tick(1);
            n++;
        end
        check({name, "_req_seen"}, int'(a2d_req), 1);
    endtask

    task automatic lit(input string name, input int e, input int l);
        check({name, "_err_lit"}, int'(err_sat), e);
        check({name, "_line_lit"}, int'(line_present), l);
    endtask

    task automatic watch_quiet(input string name, input int n);
        int req_cnt;
        int vld_cnt;
        req_cnt = 0;
        vld_cnt = 0;
        repeat (n) begin
            tick(1);
            if (a2d_req) req_cnt++;
            if (err_vld) vld_cnt++;
        end
        check({name, "_req_cycles"}, req_cnt, 0);
        check({name, "_vld_pulses"}, vld_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        set_vals(0, 0, 0, 0, 0, 0, 0, 0);
        tick(3);
        check("rst_a2d_req", int'(a2d_req), 0);
        check("rst_a2d_chnnl", int'(a2d_chnnl), 0);
        check("rst_err_vld", int'(err_vld), 0);
        check("rst_err_sat", int'(err_sat), 0);
        check("rst_line", int'(line_present), 0);
        rst_n = 1'b1;

        // go low across a wrap: nothing starts
        watch_quiet("go_low", SWEEP + 40);

        go = 1'b1;
        dly_mode = 0;
`ifndef ERR_FILTER_EN
        set_vals(0, 0, 0, 0, 0, 0, 0, 0);          run_sweep("zero");   lit("zero", 0, 0);
        set_vals(0, 0, 0, 0, 800, 0, 0, 0);        run_sweep("ch4");    lit("ch4", 50, 1);
        set_vals(0, 0, 0, 256, 0, 0, 0, 0);        run_sweep("ch3");    lit("ch3", -16, 0);
        set_vals(0, 0, 0, 0, 0, 0, 0, 4095);       run_sweep("sat_hi"); lit("sat_hi", 1023, 1);
        set_vals(4095, 0, 0, 0, 0, 0, 0, 0);       run_sweep("sat_lo"); lit("sat_lo", -1024, 1);
        set_vals(0, 0, 0, 0, 0, 'h200, 0, 0);      run_sweep("thr_eq"); lit("thr_eq", 64, 0);
        set_vals(0, 0, 0, 0, 0, 'h201, 0, 0);      run_sweep("thr_gt"); lit("thr_gt", 64, 1);
        set_vals(100, 200, 300, 400, 500, 600, 700, 800);
        run_sweep("mix");     lit("mix", 518, 1);
        dly_mode = -1;
        run_sweep("mix_rnd1"); lit("mix_rnd1", 518, 1);
        run_sweep("mix_rnd2"); lit("mix_rnd2", 518, 1);
`else
        set_vals(0, 0, 0, 0, 800, 0, 0, 0);        run_sweep("ch4");
        set_vals(0, 0, 0, 256, 0, 0, 0, 0);        run_sweep("ch3");
        set_vals(100, 200, 300, 400, 500, 600, 700, 800);
        dly_mode = -1;
        run_sweep("mix_rnd1");
`endif

        // go dropped mid-sweep: the sweep still completes
        wait_req("go_drop");
        go = 1'b0;
        run_sweep("go_drop");
`ifndef ERR_FILTER_EN
        lit("go_drop", 518, 1);
`endif
        watch_quiet("after_drop", SWEEP + 40);

        // reset while waiting in REQ
        dly_mode = 15;
        go = 1'b1;
        wait_req("rst_req");
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("rst_req_a2d_req", int'(a2d_req), 0);
        check("rst_req_err_vld", int'(err_vld), 0);
        lit("rst_req", 0, 0);
        go = 1'b0;
        tick(1);
        rst_n = 1'b1;
        watch_quiet("after_rst", SWEEP + 40);

        // two saturating sweeps from reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        dly_mode = 0;
        go = 1'b1;
        set_vals(0, 0, 0, 0, 0, 0, 0, 4095);
        run_sweep("two_a");
`ifdef ERR_FILTER_EN
        lit("filt_a", 255, 1);
`else
        lit("two_a", 1023, 1);
`endif
        run_sweep("two_b");
`ifdef ERR_FILTER_EN
        lit("filt_b", 447, 1);
`else
        lit("two_b", 1023, 1);
`endif
        go = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
